sr_button_ctrl: RTL
===================

SR_BUTTON_CTRL -- requirements
Module: sr_button_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4: consecutive cycles a synchronized button must hold a new level before the debounced level follows it.
REQ-002 SHALL have parameter PULSE_LEN, default 2: cycles each S/R pulse is held high; legal range 1..15.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port btn_set, input, 1, raw asynchronous set pushbutton.
REQ-006 SHALL have port btn_rst, input, 1, raw asynchronous reset pushbutton.
REQ-007 SHALL have port S, output, 1, registered set drive to the downstream sr_latch S input.
REQ-008 SHALL have port R, output, 1, registered reset drive to the downstream sr_latch R input.
REQ-009 SHALL have port busy, output, 1, high while a pulse is in progress.
REQ-010 SHALL have port Q_track, output, 1, the expected latch state after the issued pulses.
REQ-011 SHALL have port conflict_cnt, output, 4, saturating count of simultaneous set/reset events.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer before any other logic.
REQ-013 SHALL flip a debounced level only after the synchronized level has differed from it for DB_CYCLES consecutive cycles; any return to the old level restarts the count at 0.
REQ-014 SHALL create an event on the rising edge of a debounced level only; falling edges create no event.
REQ-015 SHALL implement FSM states IDLE, PULSE_S and PULSE_R.
REQ-016 IDLE SHALL go to PULSE_S on a set event only when Q_track=0.
REQ-017 IDLE SHALL go to PULSE_R on a reset event only when Q_track=1.
REQ-018 IDLE SHALL ignore redundant events: set when Q_track=1, or reset when Q_track=0. No pulse is issued and no counter changes.
REQ-019 SHALL apply these rules when set and reset events occur in the same cycle in IDLE:
- reset takes priority, and REQ-017/018 apply to it;
- conflict_cnt increments, saturating at 15.
REQ-020 PULSE_S SHALL drive S=1, R=0, busy=1 for exactly PULSE_LEN cycles, then return to IDLE.
REQ-021 PULSE_R SHALL drive S=0, R=1, busy=1 for exactly PULSE_LEN cycles, then return to IDLE.
REQ-022 SHALL discard events arriving in PULSE_S or PULSE_R; they are not queued and not counted.
REQ-023 SHALL never drive S=1 and R=1 in the same cycle, including during reset.
REQ-024 SHALL update Q_track on the same edge that enters the pulse state: 1 for PULSE_S, 0 for PULSE_R.
REQ-025 SHALL have the following latency, where edge k is the first edge sampling a raw input high and the input then stays high:
- the debounced level rises at edge k+1+DB_CYCLES;
- S or R is first high after edge k+2+DB_CYCLES.
REQ-026 S, R and busy SHALL be direct register outputs with no combinational path from btn_*.

Reset
REQ-027 SHALL clear the following on any edge with rst=1:
- synchronizers, debounce counters and debounced levels, to 0;
- the FSM, to IDLE;
- S, R, busy, Q_track and conflict_cnt, to 0.
REQ-028 Reset asserted mid-pulse SHALL drop S/R to 0 at that edge and abandon the pulse.
REQ-029 SHALL issue no event after reset release unless a button rises again; a button held through reset debounces as a new rising edge.

Structure
REQ-030 SHALL place the default constants DB_CYCLES_DEF=4 and PULSE_LEN_DEF=2 and the FSM state encoding in shared package sr_ctrl_pkg.
REQ-031 SHALL implement synchronizer, debounce and rising-edge detect as sub-module btn_debounce, instantiated once per button.
REQ-032 SHALL keep the FSM, pulse counter, Q_track and conflict counter in sr_button_ctrl.

Verification
REQ-033 Bench SHALL raise btn_set at edge 10 and hold it (DB=4, PULSE=2) -> S=1 after edges 16 and 17, S=0 after edge 18, Q_track=1 after edge 16, R stays 0.
REQ-034 Bench SHALL apply a 3-cycle glitch on btn_rst while Q_track=1 -> no R pulse and Q_track stays 1.
REQ-035 Bench SHALL raise both buttons on the same edge while Q_track=1 -> one R pulse of 2 cycles, Q_track=0 and conflict_cnt=1; after 16 repeats conflict_cnt=15.
REQ-036 Bench SHALL press set while Q_track=1 -> no pulse, busy stays 0, conflict_cnt unchanged.
REQ-037 Bench SHALL assert rst during the first PULSE_S cycle -> S=0, busy=0, Q_track=0 and conflict_cnt=0 after that edge.
REQ-038 Bench SHALL run random button stimulus for 10^5 cycles with an sr_latch on S/R -> S&R never 1, and latch Q equals Q_track whenever busy=0.

Source files
------------

// File: rtl/sr_ctrl_pkg.sv
// Shared constants and FSM encoding for the S/R pushbutton controller.
package sr_ctrl_pkg;

  localparam int DB_CYCLES_DEF = 4;
  localparam int PULSE_LEN_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2
  } state_e;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, counter debouncer and registered rising-edge event
// for one raw pushbutton.
module btn_debounce
  import sr_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic rise
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every _d gets a default first so no path through this block infers a latch.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    // The level flips on the DB_CYCLES-th consecutive differing cycle; any match restarts.
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/sr_button_ctrl.sv
// Turns debounced set/reset button presses into non-overlapping fixed-width
// S/R pulses for a downstream SR latch, tracking the expected latch state.
module sr_button_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int PULSE_LEN = PULSE_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_set,
  input  logic       btn_rst,
  output logic       S,
  output logic       R,
  output logic       busy,
  output logic       Q_track,
  output logic [3:0] conflict_cnt
);

  logic       set_ev, rst_ev;
  state_e     state_q, state_d;
  logic [3:0] pulse_cnt_q, pulse_cnt_d;
  logic       s_q, s_d, r_q, r_d, busy_q, busy_d, q_track_q, q_track_d;
  logic [3:0] conflict_cnt_q, conflict_cnt_d;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_set_db (
    .clk(clk), .rst(rst), .btn_raw(btn_set), .rise(set_ev)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_rst_db (
    .clk(clk), .rst(rst), .btn_raw(btn_rst), .rise(rst_ev)
  );

  always_comb begin
    state_d        = state_q;
    pulse_cnt_d    = pulse_cnt_q;
    s_d            = s_q;
    r_d            = r_q;
    busy_d         = busy_q;
    q_track_d      = q_track_q;
    conflict_cnt_d = conflict_cnt_q;
    case (state_q)
      IDLE: begin
        pulse_cnt_d = '0;
        if (set_ev && rst_ev) conflict_cnt_d = sat_inc4(conflict_cnt_q);
        // Reset wins a tie, even when it turns out redundant.
        if (rst_ev) begin
          if (q_track_q) begin
            state_d   = PULSE_R;
            r_d       = 1'b1;
            busy_d    = 1'b1;
            q_track_d = 1'b0;
          end
        end else if (set_ev && !q_track_q) begin
          state_d   = PULSE_S;
          s_d       = 1'b1;
          busy_d    = 1'b1;
          q_track_d = 1'b1;
        end
      end
      PULSE_S, PULSE_R: begin
        if (pulse_cnt_q == 4'(PULSE_LEN - 1)) begin
          state_d = IDLE;
          s_d     = 1'b0;
          r_d     = 1'b0;
          busy_d  = 1'b0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = 1'b0;
        r_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pulse_cnt_q    <= '0;
      s_q            <= 1'b0;
      r_q            <= 1'b0;
      busy_q         <= 1'b0;
      q_track_q      <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      pulse_cnt_q    <= pulse_cnt_d;
      s_q            <= s_d;
      r_q            <= r_d;
      busy_q         <= busy_d;
      q_track_q      <= q_track_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign S            = s_q;
  assign R            = r_q;
  assign busy         = busy_q;
  assign Q_track      = q_track_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule
